microplexer_cfg_loader: RTL and testbench

//  Serial configuration loader that sits directly upstream of a bank of microplexer cells.
//  It shifts a bitstream into a shadow register and checks an even-parity trailer bit.
//  On a good frame it atomically commits the shadow register to the sel4 buses of all cells.
//  The active select configuration never changes mid-load; a bad frame leaves it untouched.

---
 rtl/microplexer_cfg_loader.sv | 130 +++++++++++++
 tb/tb_microplexer_cfg_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/microplexer_cfg_loader.sv
// Serial configuration loader for a bank of microplexer cells.
//
// A frame is TOTAL data bits, MSB-first, followed by one even-parity bit. The data bits are
// shifted into a shadow register. The active select bus is updated as a whole, and only once a
// frame's parity has been checked and found good. A bad frame leaves the active select bus as
// it was.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   cfg_start  pulse that begins or restarts a frame load
//   cfg_bit    serial configuration data bit
//   cfg_valid  cfg_bit is valid this cycle
//   cfg_ready  the loader accepts a bit this cycle
//   sel_bus    active configuration; cell k select = sel_bus[SEL_W*k +: SEL_W]
//   busy       a frame load is in progress
//   cfg_done   1-cycle pulse: a frame was committed
//   cfg_err    1-cycle pulse: parity failure, the frame was discarded
module microplexer_cfg_loader #(
  parameter int unsigned NUM_CELLS = 4,
  parameter int unsigned SEL_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_bit,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic [NUM_CELLS*SEL_W-1:0] sel_bus,
  output logic                       busy,
  output logic                       cfg_done,
  output logic                       cfg_err
);

  localparam int unsigned TOTAL = NUM_CELLS * SEL_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LastDataIdx = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  state_e           state_q;
  logic [TOTAL-1:0] shadow_q;
  logic [TOTAL-1:0] sel_q;
  logic [CNT_W-1:0] count_q;
  logic             acc_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic accept;

  // ready_q is high in exactly the states that take bits, so this is the transfer handshake.
  assign accept = cfg_valid & ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      sel_q    <= '0;
      count_q  <= '0;
      acc_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // done and err are single-cycle pulses.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            state_q <= StShift;
            count_q <= '0;
            acc_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StShift, StParity: begin
          if (cfg_start) begin
            // A restart wins over any bit offered in the same cycle, so that bit is dropped.
            state_q <= StShift;
            count_q <= '0;
            acc_q   <= 1'b0;
          end else if (accept) begin
            if (state_q == StShift) begin
              shadow_q <= {shadow_q[TOTAL-2:0], cfg_bit};
              acc_q    <= acc_q ^ cfg_bit;
              count_q  <= count_q + CNT_W'(1);
              if (count_q == LastDataIdx) begin
                state_q <= StParity;
              end
            end else begin
              // This is the parity bit. With even parity, the XOR of all bits must be 0.
              if ((acc_q ^ cfg_bit) == 1'b0) begin
                sel_q  <= shadow_q;
                done_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
              state_q <= StIdle;
              count_q <= '0;
              acc_q   <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign sel_bus   = sel_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_microplexer_cfg_loader.sv
// Self-checking bench for microplexer_cfg_loader (4 cells x 4 select bits).
// For each frame, the expected commit or error outcome goes into a queue. A negedge monitor
// pops an entry each time it sees a done or err pulse and compares the two.
module tb_microplexer_cfg_loader;

  localparam int unsigned NumCells = 4;
  localparam int unsigned SelW     = 4;
  localparam int unsigned Total    = NumCells * SelW;

  typedef struct {
    logic             is_err;
    logic [Total-1:0] sel;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             cfg_start;
  logic             cfg_bit;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [Total-1:0] sel_bus;
  logic             busy;
  logic             cfg_done;
  logic             cfg_err;

  int unsigned checks;
  int unsigned errors;
  int unsigned done_cnt;
  int unsigned err_cnt;
  exp_t        sb[$];
  logic [Total-1:0] model_sel;
  logic        prev_pulse;

  microplexer_cfg_loader #(
    .NUM_CELLS(NumCells),
    .SEL_W    (SelW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .sel_bus  (sel_bus),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: match every done/err pulse with the next queued expectation.
  initial prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (rst_n && (cfg_done || cfg_err)) begin
      exp_t e;
      check_eq("pulse_width", 32'(prev_pulse), 32'd0);
      check_eq("done_err_excl", 32'(cfg_done & cfg_err), 32'd0);
      if (cfg_done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind_err", 32'(cfg_err), 32'(e.is_err));
        check_eq("sel_at_pulse", 32'(sel_bus), 32'(e.sel));
      end
    end
    prev_pulse = rst_n & (cfg_done | cfg_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap_cycles(input int unsigned n);
    for (int g = 0; g < int'(n); g++) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  // One frame: a start pulse, then the word MSB-first, then the parity bit. If
  // valid_on_start is set, a 0 bit is offered in the start cycle; it must be dropped.
  task automatic send_frame(input logic [Total-1:0] word, input logic par,
                            input bit gaps, input bit valid_on_start);
    exp_t e;
    cfg_start = 1'b1;
    cfg_valid = valid_on_start;
    cfg_bit   = 1'b0;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    for (int i = Total - 1; i >= 0; i--) begin
      if (gaps) gap_cycles((i % 2 == 1) ? $urandom_range(3, 1) : $urandom_range(3, 0));
      send_bit(word[i]);
      if (i == Total / 2) begin
        check_eq("sel_stable_midframe", 32'(sel_bus), 32'(model_sel));
        check_eq("busy_midframe", 32'(busy), 32'd1);
      end
    end
    if (gaps) gap_cycles($urandom_range(3, 0));
    e.is_err = ((($countones(word) + int'(par)) % 2) != 0);
    if (!e.is_err) model_sel = word;
    e.sel = model_sel;
    sb.push_back(e);
    send_bit(par);
    tick();
    tick();
    check_eq("sel_after_frame", 32'(sel_bus), 32'(model_sel));
    check_eq("busy_after_frame", 32'(busy), 32'd0);
    check_eq("ready_after_frame", 32'(cfg_ready), 32'd0);
  endtask

  initial begin
    int unsigned done_before;
    int unsigned err_before;
    checks    = 0;
    errors    = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    model_sel = '0;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst_sel", 32'(sel_bus), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd0);
    check_eq("rst_done", 32'(cfg_done), 32'd0);
    check_eq("rst_err", 32'(cfg_err), 32'd0);

    // 1: good frame, valid every cycle.
    send_frame(16'hA5C3, 1'b0, 1'b0, 1'b0);
    check_eq("s1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: bad parity; the previous configuration must survive.
    send_frame(16'h0001, 1'b0, 1'b0, 1'b0);
    check_eq("s2_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("s2_sel_kept", 32'(sel_bus), 32'h0000A5C3);

    // 3: the frame from scenario 1 with gaps, loaded over a different value first.
    send_frame(16'h3C00, 1'b0, 1'b0, 1'b0);
    send_frame(16'hA5C3, 1'b0, 1'b1, 1'b0);
    check_eq("s3_sel", 32'(sel_bus), 32'h0000A5C3);

    // 4: 7 ones, restart (a bit offered with the start is dropped), then 16'hFFFF.
    done_before = done_cnt;
    err_before  = err_cnt;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    send_frame(16'hFFFF, 1'b0, 1'b0, 1'b1);
    check_eq("s4_one_done", 32'(done_cnt - done_before), 32'd1);
    check_eq("s4_no_err", 32'(err_cnt - err_before), 32'd0);

    // 6: in IDLE, valid bits without a start are ignored.
    done_before = done_cnt;
    for (int i = 0; i < 20; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom);
      tick();
      check_eq("s6_ready", 32'(cfg_ready), 32'd0);
      check_eq("s6_sel", 32'(sel_bus), 32'h0000FFFF);
      check_eq("s6_pulses", 32'(cfg_done | cfg_err), 32'd0);
    end
    cfg_valid = 1'b0;

    // 5: load 16'h1234 (parity 1), then reset partway through the next frame.
    send_frame(16'h1234, 1'b1, 1'b0, 1'b0);
    check_eq("s5_sel_loaded", 32'(sel_bus), 32'h00001234);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    check_eq("s5_busy_before_rst", 32'(busy), 32'd1);
    rst_n     = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    model_sel = '0;
    check_eq("s5_sel_rst", 32'(sel_bus), 32'd0);
    check_eq("s5_busy_rst", 32'(busy), 32'd0);
    check_eq("s5_ready_rst", 32'(cfg_ready), 32'd0);
    done_before = done_cnt;
    err_before  = err_cnt;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    tick();
    check_eq("s5_sel_after", 32'(sel_bus), 32'd0);
    check_eq("s5_busy_after", 32'(busy), 32'd0);
    check_eq("s5_no_pulses", 32'((done_cnt - done_before) + (err_cnt - err_before)), 32'd0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
